rv_skid_buffer: RTL
===================

# rv_skid_buffer

Two-entry valid/ready register slice (skid buffer) that registers both the forward path (`out_valid`, `out_data`) and the backward path (`in_ready`). It sustains one transfer per cycle with no bubbles. It sits between any producer and consumer in our valid/ready streams wherever the `out_ready` → `in_ready` combinational path must be cut for timing. It complements the single-entry FIFO, which cuts only the forward path and runs at half rate under continuous traffic.

## Interface
- `DW`, default 32: payload width in bits.
- `CW`, default 32: statistics counter width; used only when `RV_SKID_STATS_EN` is defined.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `in_valid`  in  1  producer has data.
- `in_ready`  out  1  buffer accepts data; driven directly from a flop.
- `in_data`  in  DW  producer payload.
- `out_valid`  out  1  buffer presents data; driven directly from a flop.
- `out_ready`  in  1  consumer accepts data.
- `out_data`  out  DW  payload from the main register.
- `stat_clr`  in  1  synchronous clear of both counters (macro builds only).
- `stat_xfer_cnt`  out  CW  count of completed output transfers (macro builds only).
- `stat_stall_cnt`  out  CW  count of cycles with `out_valid & ~out_ready` (macro builds only).

## Operation
- Handshake events:
  - `push = in_valid & in_ready`
  - `pop = out_valid & out_ready`
- Storage: main register (drives `out_data`) and skid register. State is one of:
  - EMPTY: `out_valid=0`, `in_ready=1`.
  - BUSY: main register holds data, skid empty. `out_valid=1`, `in_ready=1`.
  - FULL: both registers hold data. `out_valid=1`, `in_ready=0`.
- Transitions:
  - EMPTY, push → BUSY; main ← `in_data`.
  - EMPTY, no push → EMPTY.
  - BUSY, push & pop → BUSY; main ← `in_data`.
  - BUSY, push & ~pop → FULL; skid ← `in_data`; main holds.
  - BUSY, pop & ~push → EMPTY.
  - BUSY, neither → BUSY.
  - FULL, pop → BUSY; main ← skid.
  - FULL, ~pop → FULL. Push is impossible because `in_ready=0`.
- Ordering: strict FIFO; the skid entry always leaves after the main entry.
- Protocol rules:
  - `out_data` is stable while `out_valid & ~out_ready`.
  - `out_valid` never drops without a pop.
  - `in_valid` is not required to wait for `in_ready`.
- The illegal state encoding (2'b11) recovers to EMPTY.

## Timing
- Reset: on a clock edge with `rst_n=0`, the block is in EMPTY with:
  - `in_ready=1`, `out_valid=0`.
  - `out_data='0` and skid register `'0`.
  - `stat_xfer_cnt=0`, `stat_stall_cnt=0`.
- Reset mid-operation discards both entries. Reset has priority over all handshakes in that cycle.
- Latency: a push at edge N produces `out_valid=1` with that data from edge N onward (one-cycle latency into an EMPTY buffer).
- Throughput: one transfer per cycle in steady BUSY with `in_valid=out_ready=1`.
- Backpressure: `in_ready` falls the cycle after a push-without-pop in BUSY. At most one extra beat is absorbed (the skid).
- Counters:
  - Wrap modulo 2^CW, no saturation.
  - `stat_clr` has priority over an increment in the same cycle.
  - Counters update one cycle after the event.

## Configuration
- `RV_SKID_STATS_EN` defined: `stat_clr`, `stat_xfer_cnt` and `stat_stall_cnt` ports and their counters exist.
- `RV_SKID_STATS_EN` undefined: those ports and their logic are absent. Datapath behaviour is identical in both builds.

## Structure
- Package `rv_pkg`:
  - `rv_skid_state_t`, an enum over logic[1:0]: EMPTY=2'b00, BUSY=2'b01, FULL=2'b10.
  - Shared constants `RV_DW_DEFAULT`=32 and `RV_CW_DEFAULT`=32.
- Sub-module `rv_stat_counter` (ports: `clk`, `rst_n`, `clr`, `inc`, `count`[CW]). Instantiated twice under the macro.

## Test plan
- Reset, then `in_valid=0`: `in_ready=1`, `out_valid=0`, `out_data=0`. Asserting `rst_n=0` while FULL empties the block on the next edge.
- Continuous stream 0x1..0x10 with `out_ready=1`: 16 transfers in 16 consecutive cycles, in order, first output one cycle after the first push.
- `out_ready=0` with pushes of 0xA, 0xB, 0xC:
  - 0xA and 0xB accepted; `in_ready=0` from the cycle after 0xB.
  - 0xC held at input.
  - Releasing `out_ready` gives outputs 0xA, 0xB, 0xC in order with no loss.
- Random `in_valid`/`out_ready` (10k cycles) against a scoreboard: no drops or duplicates, `out_data` stable under stall, `in_ready`/`out_valid` change only at edges.
- Stats build: 5 transfers and 3 stall cycles give `stat_xfer_cnt=5`, `stat_stall_cnt=3`. `stat_clr` together with a transfer gives 0.
- `CW=4` stats build, 17 transfers: `stat_xfer_cnt=1` (wrap).

Source files
------------

// File: rtl/rv_pkg.sv
// Shared types and defaults for the valid/ready register-slice blocks.
package rv_pkg;

  localparam int RV_DW_DEFAULT = 32;
  localparam int RV_CW_DEFAULT = 32;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    BUSY  = 2'b01,
    FULL  = 2'b10
  } rv_skid_state_t;

endpackage

// File: rtl/rv_skid_buffer_if.sv
// Valid/ready stream pair seen by rv_skid_buffer: producer side (in_*) and consumer side (out_*).
interface rv_skid_buffer_if
  import rv_pkg::*;
#(
  parameter int DW = RV_DW_DEFAULT
) ();

  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;

  // Environment view: drives the producer payload and the consumer ready.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  // Buffer view.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/rv_stat_counter.sv
// Wrapping event counter with synchronous clear; clear wins over increment.
module rv_stat_counter #(
  parameter int CW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] count
);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/rv_skid_buffer.sv
// Two-entry skid buffer registering both out_valid/out_data and in_ready.
// Optional statistics counters are built when RV_SKID_STATS_EN is defined.
module rv_skid_buffer
  import rv_pkg::*;
#(
  parameter int DW = RV_DW_DEFAULT,
  parameter int CW = RV_CW_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  rv_skid_buffer_if.slave    bus
`ifdef RV_SKID_STATS_EN
  ,
  input  logic               stat_clr,
  output logic [CW-1:0]      stat_xfer_cnt,
  output logic [CW-1:0]      stat_stall_cnt
`endif
);

  rv_skid_state_t state_q, state_d;
  logic [DW-1:0]  main_q, main_d;
  logic [DW-1:0]  skid_q, skid_d;
  logic           in_ready_q, in_ready_d;
  logic           out_valid_q, out_valid_d;
  logic           push;
  logic           pop;

  assign push = bus.in_valid & in_ready_q;
  assign pop  = out_valid_q & bus.out_ready;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (push) begin
          main_d  = bus.in_data;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (push && pop) begin
          main_d = bus.in_data;
        end else if (push) begin
          skid_d  = bus.in_data;
          state_d = FULL;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          main_d  = skid_q;
          state_d = BUSY;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Handshake outputs are decoded from the next state so they can leave straight from flops.
    in_ready_d  = (state_d != FULL);
    out_valid_d = (state_d != EMPTY);
  end

  // NOTE: sequential state uses non-blocking assignments; the data registers are reset
  // too because out_data must read zero after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = main_q;

`ifdef RV_SKID_STATS_EN
  rv_stat_counter #(.CW(CW)) u_xfer_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (stat_clr),
    .inc   (pop),
    .count (stat_xfer_cnt)
  );

  rv_stat_counter #(.CW(CW)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (stat_clr),
    .inc   (out_valid_q & ~bus.out_ready),
    .count (stat_stall_cnt)
  );
`endif

endmodule
